wb_hilo_unit: RTL and testbench
===============================

Name: wb_hilo_unit

Overview:
Parametrised write-back stage HI/LO block for the MIPS pipeline: owns HI/LO, runs MULT/MULTU/DIV/DIVU iteratively, and handles MTHI/MTLO.
- Muxes HI, LO or the normal write-back datum onto the register-file write port (MFHI/MFLO).
- Issues a stall while a multi-cycle operation is in flight, so the pipeline never reads stale HI/LO.

Parameters:
DATA_W, 32, operand/HI/LO width (even, >=8)
CNT_W, $clog2(DATA_W)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
op_valid  in  1  HI/LO operation presented this cycle
op_code  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (no-op)
op_a  in  DATA_W  rs operand (multiplicand/dividend/MT source)
op_b  in  DATA_W  rt operand (multiplier/divisor)
op_ready  out  1  unit can accept an op this cycle
flush  in  1  abort in-flight op (exception/branch squash)
rf_din  in  DATA_W  normal write-back datum
rd_hi  in  1  MFHI in WB
rd_lo  in  1  MFLO in WB
rf_din_out  out  DATA_W  datum to register file
hi_out  out  DATA_W  architectural HI
lo_out  out  DATA_W  architectural LO
busy  out  1  mul/div in progress
stall  out  1  pipeline must hold
done  out  1  one-cycle pulse when HI/LO updated by mul/div

Behaviour:
- Reset (rst=0, async): state IDLE; HI=LO=0; counter=0; busy=0, done=0, stall=0, op_ready=1.
- State machine: IDLE -> CALC -> FIX -> IDLE.
- op_ready = (state==IDLE). accept = op_valid & op_ready & ~flush.
- IDLE, accept of MTHI/MTLO: HI (resp. LO) <= op_a at that edge. No busy. done stays 0.
- IDLE, accept of MULT/MULTU/DIV/DIVU: latch |a|, |b| (signed ops) or raw operands, plus result signs; counter <= 0; go to CALC.
- Reserved codes: accepted, no effect.
- CALC: one bit per cycle for DATA_W cycles.
  - Multiply: shift-add into a 2*DATA_W accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - On counter==DATA_W-1, go to FIX.
- FIX: apply signs and write HI/LO at that edge.
  - Multiply: {HI,LO} = 2*DATA_W product, negated if operand signs differ.
  - Divide: LO = quotient (negated if signs differ); HI = remainder (sign of dividend).
  - done=1 in the cycle after the FIX edge. Return to IDLE.
- Latency: accept at edge t0 -> HI/LO new value visible after edge t0+DATA_W+1, i.e. 34 cycles for DATA_W=32.
- busy = state!=IDLE.
- stall = busy & (rd_hi | rd_lo | op_valid).
- Divide by zero (any sign): no trap. LO = all ones; HI = op_a unchanged.
- DIV most-negative / -1: LO = 0x80..0, HI = 0 (wraps, no trap).
- flush in CALC/FIX: return to IDLE next edge. HI/LO unchanged, done=0.
- flush in IDLE: the presented op is not accepted.
- Reset mid-operation: immediate return to reset values; the partial result is lost.
- Read mux (combinational): rd_hi ? HI : rd_lo ? LO : rf_din. rd_hi has priority if both are set.
- Reads see registered HI/LO only. MTHI accepted at an edge is visible to an MFHI in the following cycle; no same-cycle bypass.

Decomposition:
- Shared package hilo_pkg holds:
  - op_code localparams (OP_MULT..OP_MTLO)
  - state encoding (ST_IDLE, ST_CALC, ST_FIX)
- Sub-module hilo_seq_core holds the iterative shift-add/restoring datapath:
  - inputs: start, is_div, operands
  - outputs: raw product/quotient/remainder, last
- wb_hilo_unit holds the FSM, sign handling, HI/LO registers and the read mux.

Test Plan:
- MULT op_a=0xFFFFFFFD (-3), op_b=5 -> after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1; done pulses once; busy high 33 cycles.
- DIVU 100/7 -> LO=14, HI=2. DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x1234 accepted, then rd_hi=1 next cycle -> rf_din_out=0x1234.
  - During a busy MULT, rd_lo=1 -> stall=1 every cycle until done.
  - op_valid during busy -> op_ready=0, op ignored.
- flush asserted at CALC cycle 10 of MULTU 7*9 -> IDLE next cycle; prior HI/LO retained; no done.
- rst low mid-DIV -> HI=LO=0, busy=0, op_ready=1 immediately; new MULTU 7*9 then gives LO=63, HI=0.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared definitions for the write-back HI/LO unit: operation codes and
// the mul/div sequencing states.
package hilo_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/hilo_seq_core.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide,
// one bit per step, sharing a single 2*DATA_W accumulator.
module hilo_seq_core #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  step,
  input  logic                  is_div,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   prod,
  output logic [DATA_W-1:0]     quot,
  output logic [DATA_W-1:0]     rem,
  output logic                  last
);

  // acc_r: multiply -> {partial sum, remaining multiplier}; divide -> {remainder, dividend/quotient}
  logic [2*DATA_W-1:0] acc_r;
  logic [2*DATA_W-1:0] acc_next_s;
  logic [DATA_W-1:0]   opnd_r;
  logic                div_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [DATA_W:0]     mul_sum_s;
  logic [DATA_W:0]     shift_s;
  logic [DATA_W-1:0]   diff_s;
  logic                ge_s;

  // Next accumulator value for one multiply or divide iteration
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*DATA_W-1:DATA_W]}
               + (acc_r[0] ? {1'b0, opnd_r} : {(DATA_W+1){1'b0}});
    shift_s    = acc_r[2*DATA_W-1:DATA_W-1];
    ge_s       = (shift_s >= {1'b0, opnd_r});
    diff_s     = shift_s[DATA_W-1:0] - opnd_r;
    if (div_r) begin
      if (ge_s) begin
        acc_next_s = {diff_s, acc_r[DATA_W-2:0], 1'b1};
      end else begin
        acc_next_s = {shift_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b0};
      end
    end else begin
      acc_next_s = {mul_sum_s, acc_r[DATA_W-1:1]};
    end
  end

  // Operand load on start, one iteration per step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r  <= {(2*DATA_W){1'b0}};
      opnd_r <= {DATA_W{1'b0}};
      div_r  <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
    end else if (start) begin
      acc_r  <= {{DATA_W{1'b0}}, (is_div ? a : b)};
      opnd_r <= is_div ? b : a;
      div_r  <= is_div;
      cnt_r  <= {CNT_W{1'b0}};
    end else if (step) begin
      acc_r  <= acc_next_s;
      cnt_r  <= cnt_r + CNT_W'(1);
    end else begin
      acc_r  <= acc_r;
      cnt_r  <= cnt_r;
    end
  end

  assign prod = acc_r;
  assign quot = acc_r[DATA_W-1:0];
  assign rem  = acc_r[2*DATA_W-1:DATA_W];
  assign last = (cnt_r == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/wb_hilo_unit.sv
// Write-back HI/LO unit: owns HI/LO, sequences MULT/DIV through the iterative
// core, applies result signs, handles MTHI/MTLO and muxes MFHI/MFLO.
module wb_hilo_unit
  import hilo_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [2:0]        op_code,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              op_ready,
  input  logic              flush,
  input  logic [DATA_W-1:0] rf_din,
  input  logic              rd_hi,
  input  logic              rd_lo,
  output logic [DATA_W-1:0] rf_din_out,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              busy,
  output logic              stall,
  output logic              done
);

  state_t              state_r;
  logic [DATA_W-1:0]   hi_r;
  logic [DATA_W-1:0]   lo_r;
  logic                done_r;
  logic                div_r;
  logic                div0_r;
  logic                neg_q_r;
  logic                neg_rem_r;
  logic [DATA_W-1:0]   a_raw_r;

  logic                accept_s;
  logic                is_signed_s;
  logic                is_div_s;
  logic                core_start_s;
  logic                core_step_s;
  logic [DATA_W-1:0]   a_mag_s;
  logic [DATA_W-1:0]   b_mag_s;
  logic [2*DATA_W-1:0] prod_s;
  logic [DATA_W-1:0]   quot_s;
  logic [DATA_W-1:0]   rem_s;
  logic                last_s;

  assign op_ready     = (state_r == ST_IDLE);
  assign accept_s     = op_valid & op_ready & ~flush;
  assign is_signed_s  = (op_code == OP_MULT) | (op_code == OP_DIV);
  assign is_div_s     = (op_code == OP_DIV)  | (op_code == OP_DIVU);
  assign a_mag_s      = (is_signed_s & op_a[DATA_W-1]) ? -op_a : op_a;
  assign b_mag_s      = (is_signed_s & op_b[DATA_W-1]) ? -op_b : op_b;
  assign core_start_s = accept_s & ~op_code[2];
  assign core_step_s  = (state_r == ST_CALC) & ~flush;

  hilo_seq_core #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (core_start_s),
    .step   (core_step_s),
    .is_div (is_div_s),
    .a      (a_mag_s),
    .b      (b_mag_s),
    .prod   (prod_s),
    .quot   (quot_s),
    .rem    (rem_s),
    .last   (last_s)
  );

  // Sequencing FSM, HI/LO ownership and the done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      hi_r      <= {DATA_W{1'b0}};
      lo_r      <= {DATA_W{1'b0}};
      done_r    <= 1'b0;
      div_r     <= 1'b0;
      div0_r    <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      a_raw_r   <= {DATA_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            case (op_code)
              OP_MTHI: hi_r <= op_a;
              OP_MTLO: lo_r <= op_a;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                div_r     <= is_div_s;
                div0_r    <= is_div_s & (op_b == {DATA_W{1'b0}});
                neg_q_r   <= is_signed_s & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
                neg_rem_r <= is_signed_s & op_a[DATA_W-1];
                a_raw_r   <= op_a;
                state_r   <= ST_CALC;
              end
              default: ;
            endcase
          end
        end
        ST_CALC: begin
          if (flush) begin
            state_r <= ST_IDLE;
          end else if (last_s) begin
            state_r <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (flush) begin
            state_r <= ST_IDLE;
          end else begin
            // Divide by zero leaves the dividend in HI rather than a signed remainder
            if (!div_r) begin
              {hi_r, lo_r} <= neg_q_r ? -prod_s : prod_s;
            end else if (div0_r) begin
              hi_r <= a_raw_r;
              lo_r <= {DATA_W{1'b1}};
            end else begin
              hi_r <= neg_rem_r ? -rem_s  : rem_s;
              lo_r <= neg_q_r   ? -quot_s : quot_s;
            end
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Register-file write datum: MFHI wins over MFLO
  always_comb begin
    if (rd_hi) begin
      rf_din_out = hi_r;
    end else if (rd_lo) begin
      rf_din_out = lo_r;
    end else begin
      rf_din_out = rf_din;
    end
  end

  assign busy   = (state_r != ST_IDLE);
  assign stall  = busy & (rd_hi | rd_lo | op_valid);
  assign done   = done_r;
  assign hi_out = hi_r;
  assign lo_out = lo_r;

endmodule

// File: tb/tb_wb_hilo_unit.sv
// Scoreboard bench for wb_hilo_unit: expected {HI,LO} pushed at issue from an
// arithmetic reference model, popped and compared whenever done pulses.
module tb_wb_hilo_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         op_valid = 1'b0;
  logic [2:0]   op_code = 3'd0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         flush = 1'b0;
  logic [W-1:0] rf_din = '0;
  logic         rd_hi = 1'b0;
  logic         rd_lo = 1'b0;
  logic         op_ready, busy, stall, done;
  logic [W-1:0] rf_din_out, hi_out, lo_out;

  int total_cnt = 0;
  int pass_cnt  = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  wb_hilo_unit #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .op_ready(op_ready), .flush(flush),
    .rf_din(rf_din), .rd_hi(rd_hi), .rd_lo(rd_lo), .rf_din_out(rf_din_out),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference {HI,LO} from plain 64-bit / integer arithmetic
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint sa, sb;
    int qi, ri;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: r = 64'(sa * sb);
      3'd1: r = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else begin
          qi = $signed(a) / $signed(b);
          ri = $signed(a) % $signed(b);
          r = {32'(ri), 32'(qi)};
        end
      end
      3'd3: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      default: r = {hi, lo};
    endcase
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL done_unexpected: got done=1 expected no pending result");
      end else begin
        chk("hilo_result", {hi_out, lo_out}, exp_q.pop_front());
      end
    end
  end

  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit rd_during, input bit inject);
    logic [63:0] e;
    int cyc, busy_n, stall_n;
    @(negedge clk);
    op_valid = 1'b1; op_code = op; op_a = a; op_b = b;
    e = model(op, a, b, m_hi, m_lo);
    exp_q.push_back(e);
    {m_hi, m_lo} = e;
    @(negedge clk);
    op_valid = 1'b0; rd_lo = rd_during;
    cyc = 0; busy_n = 0; stall_n = 0;
    while (!done && cyc < 100) begin
      if (busy) busy_n++;
      if (stall) stall_n++;
      if (inject && cyc == 5) begin
        op_valid = 1'b1; op_code = 3'd4; op_a = $urandom;
        chk("ready_low_busy", {63'd0, op_ready}, 64'd0);
      end else begin
        op_valid = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    op_valid = 1'b0; rd_lo = 1'b0;
    chk("done_seen", {63'd0, (cyc < 100)}, 64'd1);
    chk("busy_cycles", 64'(busy_n), 64'd33);
    if (rd_during) chk("stall_cycles", 64'(stall_n), 64'd33);
    @(negedge clk);
    chk("done_single", {63'd0, done}, 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb, v;
    logic [2:0] rop;
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_lo", 64'(lo_out), 64'd0);
    chk("rst_flags", {60'd0, busy, done, stall, op_ready}, 64'd1);
    rst = 1'b1;

    run_md(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1);
    run_md(3'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    run_md(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_md(3'd3, 32'd5, 32'd0, 1'b0, 1'b0);
    run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_md(3'd2, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0);

    // MTHI/MTLO then read through the write-back mux
    @(negedge clk); op_valid = 1'b1; op_code = 3'd4; op_a = 32'h1234; m_hi = 32'h1234;
    @(negedge clk); op_code = 3'd5; op_a = 32'h5678; m_lo = 32'h5678;
    @(negedge clk); op_valid = 1'b0; rd_hi = 1'b1; rd_lo = 1'b1; rf_din = 32'hCAFE_F00D; #1;
    chk("mfhi_priority", 64'(rf_din_out), 64'h1234);
    rd_hi = 1'b0; #1;
    chk("mflo", 64'(rf_din_out), 64'h5678);
    rd_lo = 1'b0; #1;
    chk("rf_pass", 64'(rf_din_out), 64'hCAFE_F00D);

    // Flush in IDLE blocks acceptance
    @(negedge clk); op_valid = 1'b1; op_code = 3'd5; op_a = 32'hDEAD_BEEF; flush = 1'b1;
    @(negedge clk); op_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_lo", 64'(lo_out), 64'(m_lo));

    // Flush mid-calculation: back to IDLE, HI/LO kept, no done
    @(negedge clk); op_valid = 1'b1; op_code = 3'd1; op_a = 32'd7; op_b = 32'd9;
    @(negedge clk); op_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flush_busy", {62'd0, busy, op_ready}, 64'd1);
    chk("flush_hilo", {hi_out, lo_out}, {m_hi, m_lo});
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of a divide
    @(negedge clk); op_valid = 1'b1; op_code = 3'd2; op_a = 32'd1000; op_b = 32'd3;
    @(negedge clk); op_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0; #1;
    chk("rstmid_hilo", {hi_out, lo_out}, 64'd0);
    chk("rstmid_flags", {62'd0, busy, op_ready}, 64'd1);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk); rst = 1'b1;
    run_md(3'd1, 32'd7, 32'd9, 1'b0, 1'b0);
    chk("post_rst_mul", {hi_out, lo_out}, 64'd63);

    // Randomized mul/div mix, with occasional MT writes in between
    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra = $urandom;
      v = $urandom_range(0, 3);
      case (v)
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: rb = -($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_md(rop, ra, rb, (i % 2) == 1, (i % 3) == 0);
      if (i % 4 == 0) begin
        @(negedge clk); op_valid = 1'b1; op_code = 3'd4; op_a = $urandom; m_hi = op_a;
        @(negedge clk); op_valid = 1'b0; rd_hi = 1'b1; #1;
        chk("rand_mfhi", 64'(rf_din_out), 64'(m_hi));
        rd_hi = 1'b0;
      end
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
